// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   HDR_BYTE : frame start marker.
//   CNT_W    : width of the frame word count and of the word index.
//   state_t  : loader FSM states.
package imem_loader_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int         CNT_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-to-word assembler for the loader data phase.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : start of a new frame; zeroes index, partial word, checksum
//   take        : a data byte is accepted this cycle
//   byte_in     : the data byte
//   byte_idx    : position (0..3) the next data byte will occupy
//   word_next   : the word as it stands including byte_in (valid when byte_idx==3)
//   csum        : XOR of all data bytes accepted since clear
module imem_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic [31:0] word_next,
  output logic [7:0]  csum
);

  // Only the three most recent bytes need storing; the fourth arrives
  // on byte_in in the same cycle the word is consumed.
  logic [23:0] partial;

  // Little-endian: each new byte enters at the top and older bytes shift
  // down, so the first byte of a word ends up in [7:0].
  assign word_next = {byte_in, partial};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      partial  <= '0;
      byte_idx <= '0;
      csum     <= '0;
    end else if (clear) begin
      partial  <= '0;
      byte_idx <= '0;
      csum     <= '0;
    end else if (take) begin
      partial  <= word_next[31:8];
      byte_idx <= byte_idx + 2'd1;
      csum     <= csum ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream and writes it into
// instruction memory while holding the CPU in reset.
// Frame: A5, N low, N high, 4*N data bytes (little-endian words), XOR checksum.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : byte stream handshake, in_data is the byte
//   wr_valid/wr_ready   : memory write handshake, wr_addr/wr_data payload
//   cpu_hold            : keeps the core in reset until a good frame lands
//   busy, done, error   : frame in progress, good-frame pulse, sticky error
//   state               : current FSM state (debug visibility)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the source holds its payload stable while valid && !ready.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  state
);

  localparam logic [CNT_W:0] MAX_W = MAX_WORDS[CNT_W:0];

  state_t             state_q;
  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   word_idx;
  logic [CNT_W:0]     idx_next;
  logic [CNT_W-1:0]   n_full;
  logic               accept;
  logic               asm_clear;
  logic               asm_take;
  logic [1:0]         byte_idx;
  logic [31:0]        word_next;
  logic [7:0]         csum;

  assign in_ready  = (state_q != S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign state     = state_q;
  assign accept    = in_valid && in_ready;
  assign asm_clear = (state_q == S_IDLE) && accept && (in_data == HDR_BYTE);
  assign asm_take  = (state_q == S_DATA) && accept;
  // Full count as seen while the high byte is on the bus.
  assign n_full    = {in_data, n_words[7:0]};
  // One extra bit so the last-word comparison cannot wrap.
  assign idx_next  = {1'b0, word_idx} + 1'b1;

  imem_loader_word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .take      (asm_take),
    .byte_in   (in_data),
    .byte_idx  (byte_idx),
    .word_next (word_next),
    .csum      (csum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      n_words  <= '0;
      word_idx <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Anything other than the header is line noise and is dropped.
          if (accept && in_data == HDR_BYTE) begin
            state_q  <= S_LEN_LO;
            cpu_hold <= 1'b1;
            error    <= 1'b0;
            word_idx <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            n_words <= {8'h00, in_data};
            state_q <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            n_words <= n_full;
            if ({1'b0, n_full} > MAX_W) begin
              error   <= 1'b1;
              state_q <= S_IDLE;
            end else if (n_full == '0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (asm_take && byte_idx == 2'd3) begin
            wr_data  <= word_next;
            wr_addr  <= BASE_ADDR + {14'b0, word_idx, 2'b00};
            wr_valid <= 1'b1;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          // in_ready is low here, so the stream stalls until memory accepts.
          if (wr_ready) begin
            wr_valid <= 1'b0;
            word_idx <= idx_next[CNT_W-1:0];
            state_q  <= (idx_next < {1'b0, n_words}) ? S_DATA : S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames, a table of frame vectors,
// and randomized frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .state    (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          vec_count   = 0;
  int          miscompares = 0;
  int          done_cnt    = 0;
  logic [63:0] exp_q[$];           // {addr, data} of expected writes
  int          stall_cycles = 0;
  bit          rand_stall   = 1'b0;
  int          wcnt         = 0;
  int          cur_delay    = 0;
  logic [31:0] held_addr;
  logic [31:0] held_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory-side responder and write monitor, sampled on the falling edge.
  always @(negedge clk) begin : mem_side
    logic [63:0] e;
    if (wr_valid) begin
      if (wcnt == 0) begin
        held_addr = wr_addr;
        held_data = wr_data;
        cur_delay = rand_stall ? int'($urandom_range(0, 3)) : stall_cycles;
      end else begin
        check("wr_addr_stable", wr_addr, held_addr);
        check("wr_data_stable", wr_data, held_data);
      end
      check("in_ready_in_write", in_ready, 1'b0);
      wr_ready = (wcnt >= cur_delay);
      if (wr_ready) begin
        if (exp_q.size() == 0) begin
          vec_count++;
          miscompares++;
          $display("FAIL unexpected_write: actual %0h@%0h required none", wr_data, wr_addr);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", wr_addr, e[63:32]);
          check("write_data", wr_data, e[31:0]);
        end
      end
      wcnt++;
    end else begin
      wr_ready = 1'b0;
      wcnt     = 0;
    end
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      vec_count++;
      miscompares++;
      $display("FAIL in_ready_timeout: actual stalled required accept");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Reference model: serialises a frame from the format rules and queues
  // the writes memory should see.
  task automatic send_frame(input int n, input logic [31:0] words[$], input int csum_force);
    logic [7:0]  cs = 8'h00;
    logic [7:0]  b;
    logic [15:0] nf = 16'(n);
    send_byte(8'hA5);
    send_byte(nf[7:0]);
    send_byte(nf[15:8]);
    if (n > MAXW) return;
    for (int i = 0; i < n; i++) exp_q.push_back({BASE + 32'(4 * i), words[i]});
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = 8'((words[i] >> (8 * k)) & 32'hFF);
        cs = cs ^ b;
        send_byte(b);
      end
    end
    send_byte(csum_force >= 0 ? 8'(csum_force) : cs);
  endtask

  task automatic check_outcome(input string name, input int d0, input bit exp_done, input bit exp_err);
    repeat (2) @(negedge clk);
    check({name, "_done"}, 64'(done_cnt - d0), 64'(exp_done));
    check({name, "_error"}, error, exp_err);
    check({name, "_cpu_hold"}, cpu_hold, !exp_done);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_frame(input int n, input bit corrupt, input bit exp_done, input bit exp_err,
                           input string name);
    logic [31:0] words[$];
    logic [7:0]  cs = 8'h00;
    int d0 = done_cnt;
    for (int i = 0; i < n && i <= MAXW; i++) begin
      words.push_back($urandom);
      for (int k = 0; k < 4; k++) cs = cs ^ 8'((words[i] >> (8 * k)) & 32'hFF);
    end
    send_frame(n, words, corrupt ? int'(cs ^ 8'h01) : -1);
    check_outcome(name, d0, exp_done, exp_err);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, in_ready, 1'b1);
    check({name, "_wr_valid"}, wr_valid, 1'b0);
    check({name, "_wr_addr"}, wr_addr, 32'h0);
    check({name, "_wr_data"}, wr_data, 32'h0);
    check({name, "_cpu_hold"}, cpu_hold, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_error"}, error, 1'b0);
  endtask

  // ---------------- frame vector table ----------------
  typedef struct {
    int n;
    bit corrupt;
    bit exp_done;
    bit exp_err;
  } vec_t;

  vec_t tbl[8];

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] w[$];
    int d0;

    tbl[0] = '{n: 1,     corrupt: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    tbl[1] = '{n: 3,     corrupt: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    tbl[2] = '{n: 0,     corrupt: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    tbl[3] = '{n: 0,     corrupt: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    tbl[4] = '{n: 256,   corrupt: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    tbl[5] = '{n: 257,   corrupt: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    tbl[6] = '{n: 65535, corrupt: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    tbl[7] = '{n: 4,     corrupt: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

    // Reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);

    // Two-word program, memory always ready
    w = '{32'h0000_0013, 32'h0010_0093};
    d0 = done_cnt;
    send_frame(2, w, -1);
    check_outcome("basic", d0, 1'b1, 1'b0);

    // Same program with 5-cycle write stalls
    stall_cycles = 5;
    d0 = done_cnt;
    send_frame(2, w, -1);
    check_outcome("stall", d0, 1'b1, 1'b0);
    stall_cycles = 0;

    // Bad checksum: words still land, error set, core held
    d0 = done_cnt;
    send_frame(2, w, 8'h81);
    check_outcome("badcsum", d0, 1'b0, 1'b1);

    // Oversized count, then a good frame clears the error
    d0 = done_cnt;
    send_frame(257, w, -1);
    check_outcome("oversize", d0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b1, 1'b0, "recover");

    // Noise before header, empty frame
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    check("noise_busy", busy, 1'b0);
    d0 = done_cnt;
    send_frame(0, w, -1);
    check_outcome("empty", d0, 1'b1, 1'b0);

    // Reset asserted during the third data byte
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    #2 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset_next");
    reset = 1'b1;
    run_frame(3, 1'b0, 1'b1, 1'b0, "after_reset");

    // Table of frame vectors
    rand_stall = 1'b1;
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].n, tbl[i].corrupt, tbl[i].exp_done, tbl[i].exp_err, $sformatf("tbl%0d", i));

    // Randomized frames: outcome follows from the checksum rule alone
    for (int i = 0; i < 20; i++) begin
      int n;
      bit c;
      n = $urandom_range(0, 10);
      c = ($urandom_range(0, 3) == 0);
      run_frame(n, c, !c, c, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
